// File: rtl/aha_clk_select_pkg.sv
// Shared types and constants for the clock-select controller.
// Holds the controller state encoding and the minimum SETTLE dwell used with acknowledgements.
package aha_clk_select_pkg;

  localparam int STATE_W    = 2;
  localparam int MIN_SETTLE = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/aha_clk_select_ctrl_sync2.sv
// aha_sync2: generic two-flop synchronizer into the destination clock.
// Asynchronous active-high reset clears both stages to 0.
module aha_sync2 (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/aha_clk_select_ctrl.sv
// Drives the glitch-free clock switch SELECT line and times the settle/hold windows.
// Optional macro AHA_CLK_SELECT_ACK_EN: SETTLE ends on synchronized switch enables, with a sticky TIMEOUT.
module aha_clk_select_ctrl
  import aha_clk_select_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int HOLD_CYCLES    = 8,
  parameter int CNT_W          = 8,
  parameter int RESET_SEL      = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_req_valid,
  input  logic i_req_sel,
  output logic o_req_ready,
  output logic o_select,
  output logic o_busy,
  output logic o_done
`ifdef AHA_CLK_SELECT_ACK_EN
  ,
  input  logic i_enable0_ack,
  input  logic i_enable1_ack,
  output logic o_timeout
`endif
);

  if ((SETTLE_CYCLES < 1) || (HOLD_CYCLES < 0) || (TIMEOUT_CYCLES < MIN_SETTLE) ||
      (longint'(SETTLE_CYCLES) >= (longint'(1) << CNT_W)) ||
      (longint'(HOLD_CYCLES) >= (longint'(1) << CNT_W)) ||
      (longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_W))) begin : g_bad_cfg
    $error("aha_clk_select_ctrl: invalid parameter set");
  end

  localparam logic             RST_SEL_BIT = (RESET_SEL != 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_select;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_settle_exit;
  logic             w_cnt_zero;

  assign w_accept   = i_req_valid & r_ready;
  assign w_cnt_zero = (r_cnt == '0);

`ifdef AHA_CLK_SELECT_ACK_EN
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_MARK    = CNT_W'(TIMEOUT_CYCLES - MIN_SETTLE);

  logic w_en0_sync;
  logic w_en1_sync;
  logic w_ack_ok;
  logic w_timed_out;
  logic r_timeout;

  aha_sync2 u_sync_en0 (.i_clk(i_clk), .i_reset(i_reset), .i_d(i_enable0_ack), .o_q(w_en0_sync));
  aha_sync2 u_sync_en1 (.i_clk(i_clk), .i_reset(i_reset), .i_d(i_enable1_ack), .o_q(w_en1_sync));

  // The ack is trusted only once SETTLE has lasted MIN_SETTLE cycles (counter has fallen to MIN_MARK).
  assign w_ack_ok      = (r_cnt <= MIN_MARK) &
                         (r_select ? (w_en1_sync & ~w_en0_sync) : (w_en0_sync & ~w_en1_sync));
  assign w_settle_exit = w_ack_ok | w_cnt_zero;
  assign w_timed_out   = w_cnt_zero & ~w_ack_ok;
  assign o_timeout     = r_timeout;
`else
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  assign w_settle_exit = w_cnt_zero;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_select <= RST_SEL_BIT;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef AHA_CLK_SELECT_ACK_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
`ifdef AHA_CLK_SELECT_ACK_EN
            r_timeout <= 1'b0;
`endif
            if (i_req_sel == r_select) begin
              r_done <= 1'b1;
            end else begin
              r_select <= i_req_sel;
              r_state  <= SETTLE;
              r_cnt    <= SETTLE_LOAD;
              r_ready  <= 1'b0;
              r_busy   <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (w_settle_exit) begin
            r_done <= 1'b1;
`ifdef AHA_CLK_SELECT_ACK_EN
            if (w_timed_out) r_timeout <= 1'b1;
`endif
            // With no guard window the DONE cycle is already an IDLE cycle.
            if (HOLD_CYCLES == 0) begin
              r_state <= IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= HOLD;
              r_cnt   <= HOLD_LOAD;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (w_cnt_zero) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = r_ready;
  assign o_select    = r_select;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_aha_clk_select_ctrl.sv
// Self-checking bench for aha_clk_select_ctrl with default parameters.
// Expected outputs come from a cycle-number model: when DONE fires, when READY returns, what SELECT holds.
module tb_aha_clk_select_ctrl;

  localparam int S = 16;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic reqValid = 1'b0;
  logic reqSel = 1'b0;
  logic reqReady;
  logic selectOut;
  logic busy;
  logic done;
`ifdef AHA_CLK_SELECT_ACK_EN
  logic en0Ack = 1'b0;
  logic en1Ack = 1'b0;
  logic timeoutOut;
`endif

  int compared = 0;
  int mismatched = 0;

  int cycle = 0;
  int readyAt = 0;
  int doneAt = -1;
  logic expSel = 1'b0;

  aha_clk_select_ctrl dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_req_valid(reqValid),
    .i_req_sel(reqSel),
    .o_req_ready(reqReady),
    .o_select(selectOut),
    .o_busy(busy),
    .o_done(done)
`ifdef AHA_CLK_SELECT_ACK_EN
    ,
    .i_enable0_ack(en0Ack),
    .i_enable1_ack(en1Ack),
    .o_timeout(timeoutOut)
`endif
  );

  always #5 clk = ~clk;

  // Compares all outputs against the model's view of the current cycle.
  task automatic checkOutput(input string tag);
    logic expReady;
    logic expDone;
    expReady = (cycle >= readyAt);
    expDone  = (cycle == doneAt);
    compared += 4;
    assert (reqReady === expReady) else begin
      mismatched++;
      $error("[TB] FAIL %s.ready cyc=%0d got=%b exp=%b", tag, cycle, reqReady, expReady);
    end
    assert (busy === !expReady) else begin
      mismatched++;
      $error("[TB] FAIL %s.busy cyc=%0d got=%b exp=%b", tag, cycle, busy, !expReady);
    end
    assert (done === expDone) else begin
      mismatched++;
      $error("[TB] FAIL %s.done cyc=%0d got=%b exp=%b", tag, cycle, done, expDone);
    end
    assert (selectOut === expSel) else begin
      mismatched++;
      $error("[TB] FAIL %s.select cyc=%0d got=%b exp=%b", tag, cycle, selectOut, expSel);
    end
  endtask

  // Called #1 after a rising edge: check, drive, advance one cycle, update the model.
  task automatic applyStimulus(input string tag, input logic v, input logic s);
    logic acc;
    checkOutput(tag);
    reqValid = v;
    reqSel   = s;
    acc = v && (cycle >= readyAt);
    @(posedge clk);
    cycle++;
    if (acc) begin
      if (s == expSel) begin
        doneAt = cycle;
      end else begin
        expSel  = s;
        doneAt  = cycle + S;
        readyAt = cycle + S + H;
      end
    end
    #1;
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    reqValid = 1'b0;
    expSel  = 1'b0;
    readyAt = 0;
    doneAt  = -1;
    cycle   = 0;
    #1;
    checkOutput(tag);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] start");
    rst = 1'b1;
    #12;
    doReset("rst0");

    // Switch 0->1 accepted at cycle 10.
    for (int i = 0; i < 10; i++) applyStimulus("idle", 1'b0, 1'b0);
    applyStimulus("acc01", 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) applyStimulus("sw01", 1'b0, 1'b0);

    // Same target request.
    doReset("rst1");
    for (int i = 0; i < 5; i++) applyStimulus("idle2", 1'b0, 1'b0);
    applyStimulus("same", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("same_after", 1'b0, 1'b0);

    // Request held valid with toggling target while busy.
    applyStimulus("busy_acc", 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus("busy_tog", 1'b1, 1'(i % 2));
    applyStimulus("busy_end", 1'b0, 1'b0);

    // Abort mid-SETTLE: no DONE may follow the aborted request.
    doReset("rst2");
    for (int i = 0; i < 10; i++) applyStimulus("idle3", 1'b0, 1'b0);
    applyStimulus("acc_abort", 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus("settle", 1'b0, 1'b0);
    doReset("rst_mid");
    for (int i = 0; i < 30; i++) applyStimulus("post_abort", 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++)
      applyStimulus("rand", 1'(($urandom % 4) == 0), 1'($urandom));
    for (int i = 0; i < 30; i++) applyStimulus("drain", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/aha_clk_select_ctrl.md
Name: aha_clk_select_ctrl

Overview:
Control stage directly upstream of the glitch-free two-input clock switch. It accepts clock-source change requests over a valid/ready handshake and drives the switch's SELECT line. It then holds off for a settle window so the switch's cross-domain enable handshake can finish, and signals completion. It runs on an always-on clock, independent of both switched clocks, and sits in the platform controller between the register interface and the clock switch.

Parameters:
SETTLE_CYCLES, 16, cycles SELECT is held stable before DONE is asserted (must be >= 1).
HOLD_CYCLES, 8, guard cycles after DONE before a new request is accepted (>= 0).
CNT_W, 8, width of the shared down-counter; must hold max(SETTLE_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES).
RESET_SEL, 0, SELECT value at reset (0 = MASTER_CLK0, 1 = MASTER_CLK1).
TIMEOUT_CYCLES, 255, acknowledgement timeout; used only with the optional feature.

Ports:
CLK  in  1  always-on control clock.
RESET  in  1  reset, asynchronous, active-high.
REQ_VALID  in  1  change request valid.
REQ_SEL  in  1  target clock source for the request.
REQ_READY  out  1  controller can accept a request.
SELECT  out  1  registered select line to the clock switch.
BUSY  out  1  high in any state other than IDLE.
DONE  out  1  one-cycle completion pulse.
ENABLE0_ACK  in  1  clk0 enable from the switch (macro only).
ENABLE1_ACK  in  1  clk1 enable from the switch (macro only).
TIMEOUT  out  1  sticky acknowledgement-timeout flag (macro only).

Behaviour:
- One clock domain, CLK. RESET is asynchronous and active-high.
- Reset values: SELECT = RESET_SEL, REQ_READY = 1, BUSY = 0, DONE = 0, TIMEOUT = 0, state = IDLE, counter = 0. All outputs are registered.
- States: IDLE, SETTLE, HOLD.
- Accept: a request is accepted on a cycle N where REQ_VALID & REQ_READY. REQ_READY is high only in IDLE. REQ_SEL is sampled only on the accept cycle. Requests while busy are never acknowledged and are not queued.
- Same-target request (REQ_SEL == SELECT):
  - No SELECT change, no SETTLE or HOLD.
  - DONE pulses at N+1; controller stays in IDLE.
- Different target:
  - At N+1, SELECT = REQ_SEL, state = SETTLE, counter = SETTLE_CYCLES-1.
  - SETTLE lasts exactly SETTLE_CYCLES cycles.
  - DONE pulses at N+1+SETTLE_CYCLES.
  - HOLD occupies HOLD_CYCLES cycles, starting on the DONE cycle.
  - REQ_READY rises at N+1+SETTLE_CYCLES+HOLD_CYCLES.
  - With HOLD_CYCLES = 0, the controller returns to IDLE on the DONE cycle and REQ_READY is high in that cycle.
- Counter: a single CNT_W down-counter, reloaded on each state entry. It never wraps; reaching 0 triggers the state transition.
- SELECT changes only on the IDLE->SETTLE transition. It is never toggled during SETTLE or HOLD.
- DONE is high only on the defined completion cycle, never for two consecutive cycles.
- Reset asserted mid-operation:
  - Immediate return to reset values; SELECT = RESET_SEL even if a switch was in flight.
  - No DONE pulse is emitted for the aborted request.
- Back-to-back: a request held valid across HOLD is accepted on the first IDLE cycle.

Optional Feature:
Macro AHA_CLK_SELECT_ACK_EN.
- When defined:
  - ENABLE0_ACK and ENABLE1_ACK ports exist. Each is passed through a 2-flop synchronizer into CLK.
  - SETTLE exits on the first cycle where the synced target enable = 1 and the synced other enable = 0, evaluated after a minimum of 2 cycles in SETTLE.
  - If that condition is not met within TIMEOUT_CYCLES, SETTLE exits anyway, DONE pulses, and TIMEOUT is set.
  - TIMEOUT is sticky and clears on the next accepted request or on reset.
  - SETTLE_CYCLES is unused.
- When undefined: the ack ports and TIMEOUT are absent, and SETTLE uses the fixed SETTLE_CYCLES count.

Decomposition:
- Package aha_clk_select_pkg: state enum (IDLE, SETTLE, HOLD), the state-width constant, and the minimum-settle constant (2).
- Sub-module aha_sync2: generic 2-flop synchronizer, asynchronous active-high reset to 0. It is instantiated only under the macro.

Test Plan:
- Reset: assert RESET asynchronously mid-cycle -> SELECT = 0, REQ_READY = 1, BUSY = 0, DONE = 0 immediately.
- Switch 0->1 with defaults: REQ_VALID=1, REQ_SEL=1 accepted at cycle 10 -> SELECT = 1 at cycle 11, DONE only at cycle 27, REQ_READY high again at cycle 35.
- Same target: SELECT = 0, request REQ_SEL=0 accepted at cycle 5 -> DONE at cycle 6, BUSY stays 0, SELECT unchanged.
- Busy rejection: hold REQ_VALID=1 with REQ_SEL toggling during SETTLE and HOLD -> REQ_READY = 0 and SELECT stable; the first IDLE cycle accepts the value present then.
- Reset mid-SETTLE: RESET at cycle 15 of a 0->1 switch -> SELECT back to 0, no DONE ever observed for that request.
- Macro on: acks never arrive -> DONE at accept+1+255 and TIMEOUT = 1; the next accepted request with acks arriving after 4 cycles clears TIMEOUT and gives DONE within 7 cycles of accept.
